// File: rtl/shot_clock_pkg.sv
// Shared types and defaults for the shot-clock push-button front end.
// Holds the control FSM state encoding, default timing constants and a width helper.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_PAUSE = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int DEF_DB_CYC   = 1_000_000;  // 20 ms at 50 MHz
    localparam int DEF_HOLD_CYC = 1000;

    // Counter width for a count that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes one raw active-low key, debounces it and emits a one-cycle
// registered pulse when the debounced level falls (press). Releases are silent.
module key_debounce
    import shot_clock_pkg::*;
#(
    parameter int DB_CYC = DEF_DB_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    localparam int              W       = cnt_width(DB_CYC);
    localparam logic [W-1:0]    CNT_MAX = W'(DB_CYC - 1);

    logic [1:0]   sync_q;
    logic         synced;
    logic [W-1:0] cnt_q;
    logic         level_q;
    logic         level_d1_q;
    logic         press_q;

    assign synced = sync_q[1];

    // NOTE: async active-low reset; every flop here is state, so all use <= to avoid
    // ordering races between the synchronizer stages and the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key};
        end
    end

    // The level only flips after DB_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else if (synced == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            level_q <= ~level_q;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d1_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            level_d1_q <= level_q;
            press_q    <= level_d1_q & ~level_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/shot_clock_keys.sv
// Referee key front end for the 24-second shot clock: debounced reset and run/pause
// keys drive a clear/pause/run FSM that controls the timer core's nRST/nPAUSE.
module shot_clock_keys
    import shot_clock_pkg::*;
#(
    parameter int DB_CYC   = DEF_DB_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic CLK_50,
    input  logic nCLR,
    input  logic KEY_RST,
    input  logic KEY_RUN,
    input  logic Alarm,
    output logic nTimerRST,
    output logic nTimerPAUSE,
    output logic RunLED
);

    localparam int           HW       = cnt_width(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);

    logic          rst_press;
    logic          run_press;
    logic [1:0]    alarm_sync_q;
    logic          alarm_synced;
    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;

    key_debounce #(.DB_CYC(DB_CYC)) u_rst_key (
        .clk   (CLK_50),
        .rst_n (nCLR),
        .key   (KEY_RST),
        .press (rst_press)
    );

    key_debounce #(.DB_CYC(DB_CYC)) u_run_key (
        .clk   (CLK_50),
        .rst_n (nCLR),
        .key   (KEY_RUN),
        .press (run_press)
    );

    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            alarm_sync_q <= 2'b00;
        end else begin
            alarm_sync_q <= {alarm_sync_q[0], Alarm};
        end
    end

    assign alarm_synced = alarm_sync_q[1];

    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= S_CLEAR;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (rst_press) begin
            // A reset press always restarts the full clear pulse, even mid-clear.
            state_d = S_CLEAR;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    if (hold_q == HOLD_MAX) begin
                        state_d = S_PAUSE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                S_PAUSE: begin
                    if (run_press && !alarm_synced) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (alarm_synced || run_press) begin
                        state_d = S_PAUSE;
                    end
                end
                default: begin
                    state_d = S_CLEAR;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Outputs decode the state register only; no input reaches them combinationally.
    always_comb begin
        nTimerRST   = 1'b0;
        nTimerPAUSE = 1'b0;
        RunLED      = 1'b0;
        unique case (state_q)
            S_PAUSE: begin
                nTimerRST = 1'b1;
            end
            S_RUN: begin
                nTimerRST   = 1'b1;
                nTimerPAUSE = 1'b1;
                RunLED      = 1'b1;
            end
            default: begin
                nTimerRST   = 1'b0;
                nTimerPAUSE = 1'b0;
                RunLED      = 1'b0;
            end
        endcase
    end

endmodule
